tdm_demux_1x8: RTL
==================

TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 din  input  1  serial TDM data bit for the current slot.
REQ-005 din_valid  input  1  din and sync qualified this cycle; all other inputs ignored when low.
REQ-006 sync  input  1  frame marker; when high with din_valid, din belongs to slot 0.
REQ-007 y  output  8  registered frame; y[k] = bit received in slot k of last complete frame.
REQ-008 frame_valid  output  1  one-cycle pulse: y updated this cycle.
REQ-009 slot  output  3  slot index the next valid bit will occupy (registered).
REQ-010 locked  output  1  high in LOCK state.
REQ-011 sync_err  output  1  one-cycle pulse: sync arrived at a slot other than 0 while locked.

Function
REQ-012 The FSM SHALL have two states: HUNT and LOCK.
REQ-013 In HUNT, valid bits without sync SHALL be discarded; slot stays 0, shadow unchanged.
REQ-014 In HUNT, din_valid=1 with sync=1 SHALL store din in shadow[0], set slot=1, and enter LOCK.
REQ-015 sync with din_valid=0 SHALL be ignored in every state.
REQ-016 In LOCK, din_valid=1 with sync=0 SHALL store din in shadow[slot] and increment slot, wrapping 7->0.
REQ-017 In LOCK, din_valid=1, sync=1, slot=0 SHALL be treated as a normal slot-0 bit (no error).
REQ-018 In LOCK, din_valid=1, sync=1, slot!=0 SHALL: pulse sync_err next cycle, clear shadow to 0, store din in shadow[0], set slot=1, stay in LOCK; the partial frame is dropped and y is unchanged.
REQ-019 When a valid non-realigning bit is stored at slot=7, the same edge SHALL load y <= {din, shadow[6:0]} and assert frame_valid for exactly the following cycle.
REQ-020 Latency: y and frame_valid SHALL become visible one clock after the edge sampling the slot-7 bit.
REQ-021 y SHALL hold its value between frames; frame_valid SHALL be low except on update cycles.
REQ-022 din_valid=0 cycles inside a frame SHALL not advance slot or alter shadow (gaps allowed).
REQ-023 frame_valid and sync_err SHALL never be high in the same cycle.
REQ-024 Slot-7 bit with sync=1 (slot!=0) SHALL follow REQ-018, not REQ-019.

Reset
REQ-025 rst=1 at a clock edge SHALL force: state HUNT, slot=0, shadow=0, y=8'h00, frame_valid=0, sync_err=0, locked=0.
REQ-026 Reset SHALL take priority over all inputs, including mid-frame; partial frames are discarded and y cleared.
REQ-027 Outputs SHALL be defined (not X) from the first edge with rst=1.

Verification
REQ-028 Reset, then 8 valid bits 1,0,1,1,0,0,1,0 with sync on first -> y=8'h4D, frame_valid one pulse, locked=1, slot=0.
REQ-029 In HUNT send 5 valid bits without sync -> all discarded, locked=0, slot=0, no frame_valid; then full frame for 8'hA5 -> y=8'hA5.
REQ-030 Locked; send 3 bits, then sync with din=1 -> sync_err one pulse, slot=1, y unchanged; 7 more bits all 0 -> y=8'h01.
REQ-031 Frame 8'h3C with din_valid=0 gaps of 1-3 cycles between bits -> y=8'h3C, single frame_valid, slot stalls during gaps.
REQ-032 Two back-to-back frames 8'hFF then 8'h00 with sync each frame -> two frame_valid pulses 8 cycles apart, no sync_err, y=8'hFF then 8'h00.
REQ-033 Assert rst after 4 bits of a locked frame -> next cycle y=8'h00, locked=0, slot=0; subsequent non-sync bits discarded.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// 1-to-8 TDM serial demultiplexer: hunts for a frame marker, then collects eight
// slot bits into a shadow register and publishes each complete frame on y.
module tdm_demux_1x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [7:0] y,
  output logic       frame_valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] y_q, y_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sync_err_q, sync_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      slot_q        <= 3'd0;
      shadow_q      <= 8'h00;
      y_q           <= 8'h00;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (din_valid && sync) begin
          shadow_d[0] = din;
          slot_d      = 3'd1;
          state_d     = StLock;
        end
      end
      StLock: begin
        if (din_valid) begin
          if (sync && (slot_q != 3'd0)) begin
            // Misplaced marker: drop the partial frame and realign on this bit.
            sync_err_d = 1'b1;
            shadow_d   = {7'b0, din};
            slot_d     = 3'd1;
          end else begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + 3'd1;
            if (slot_q == 3'd7) begin
              y_d           = {din, shadow_q[6:0]};
              frame_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  assign y           = y_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == StLock);
  assign sync_err    = sync_err_q;

endmodule
